// File: rtl/disp_pix_prefetch.sv
// Display pixel prefetcher: issues burst reads to the frame buffer, holds returned
// RGB565 words in a show-ahead FIFO and restarts at the frame base on every vsync rise.
module disp_pix_prefetch #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned H_VALID   = 1024,
    parameter int unsigned V_VALID   = 768,
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              pix_data_req,
    output logic [15:0]       pix_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_valid,
    input  logic [15:0]       rd_data,
    output logic              underflow
);

    localparam int unsigned FRAME_WORDS = H_VALID * V_VALID;
    localparam int unsigned CNT_W       = $clog2(FRAME_WORDS) + 1;
    localparam int unsigned PTR_W       = $clog2(DEPTH);
    localparam int unsigned FCNT_W      = PTR_W + 1;
    localparam int unsigned OUT_W       = PTR_W + 2;
    localparam int unsigned SUM_W       = OUT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                vsync_q;
    logic                rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]    req_cnt_q, req_cnt_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic [FCNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                underflow_q, underflow_d;
    logic [15:0]         mem_q [DEPTH];

    logic vsync_rise_c, ack_c, valid_ok_c, empty_c, flush_c, push_c, pop_c, credit_c;

    assign vsync_rise_c = vsync & ~vsync_q;
    assign ack_c        = rd_req_q & rd_ack;
    // A returned word with nothing outstanding is stray and must not touch any counter.
    assign valid_ok_c   = rd_valid && (out_q != '0);
    assign empty_c      = (fifo_cnt_q == '0);
    assign flush_c      = (state_d == ST_FLUSH);
    assign push_c       = (state_q == ST_RUN) && valid_ok_c && !flush_c;
    assign pop_c        = pix_data_req && !empty_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (vsync_rise_c) state_d = ST_FLUSH;
            ST_FLUSH: if (out_q == '0 && !rd_req_q) state_d = ST_RUN;
            ST_RUN:   if (vsync_rise_c) state_d = ST_FLUSH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and request logic; credit is judged on post-update counters.
    always_comb begin
        rd_addr_d   = rd_addr_q;
        req_cnt_d   = req_cnt_q;
        out_d       = out_q;
        fifo_cnt_d  = fifo_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        underflow_d = underflow_q;
        rd_req_d    = 1'b0;
        credit_c    = 1'b0;

        if (ack_c) begin
            rd_addr_d = rd_addr_q + ADDR_W'(BURST_LEN);
            req_cnt_d = req_cnt_q + CNT_W'(BURST_LEN);
        end
        out_d = out_q + (ack_c ? OUT_W'(BURST_LEN) : OUT_W'(0))
                      - (valid_ok_c ? OUT_W'(1) : OUT_W'(0));

        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        fifo_cnt_d = fifo_cnt_q + FCNT_W'(push_c) - FCNT_W'(pop_c);
        if (pix_data_req && empty_c) underflow_d = 1'b1;

        // A pending request keeps its address until acked; the frame restarts after.
        if (flush_c) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fifo_cnt_d  = '0;
            req_cnt_d   = '0;
            underflow_d = 1'b0;
            if (!(rd_req_q && !rd_ack)) rd_addr_d = ADDR_W'(BASE_ADDR);
        end

        credit_c = (SUM_W'(fifo_cnt_d) + SUM_W'(out_d) + SUM_W'(BURST_LEN) <= SUM_W'(DEPTH))
                   && (req_cnt_d < CNT_W'(FRAME_WORDS));
        rd_req_d = (rd_req_q && !rd_ack) || ((state_d == ST_RUN) && credit_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q     <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= ADDR_W'(BASE_ADDR);
            req_cnt_q   <= '0;
            out_q       <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            req_cnt_q   <= req_cnt_d;
            out_q       <= out_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            underflow_q <= underflow_d;
        end
    end

    // FIFO storage needs no reset; emptiness is tracked by fifo_cnt_q.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= rd_data;
    end

    assign pix_data  = empty_c ? 16'h0000 : mem_q[rd_ptr_q];
    assign rd_req    = rd_req_q;
    assign rd_addr   = rd_addr_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_disp_pix_prefetch.sv
// Bench for disp_pix_prefetch: a frame-buffer responder plus a frame-order pixel model.
`timescale 1ns/1ps
module tb_disp_pix_prefetch;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned BL    = 4;
    localparam int unsigned HV    = 8;
    localparam int unsigned VV    = 2;
    localparam int unsigned AW    = 24;
    localparam int unsigned BASE  = 32'h100;
    localparam int unsigned FRAME = HV * VV;

    logic          clk = 1'b0;
    logic          rst;
    logic          vsync;
    logic          pix_data_req;
    logic [15:0]   pix_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic          rd_valid;
    logic [15:0]   rd_data;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    logic [15:0] sdram [FRAME];
    int          owed_q[$];
    int          owed_next[$];
    int          req_log[$];
    logic [15:0] model_q[$];
    logic [15:0] pop_got[$];
    int          discard = 0;
    bit          stale_req = 0;
    bit          req_held = 0;
    logic [AW-1:0] held_addr = '0;
    bit          uf_exp = 0;
    int          head_bad = 0;
    int          addr_unstable = 0;

    disp_pix_prefetch #(
        .DEPTH(DEPTH), .BURST_LEN(BL), .H_VALID(HV), .V_VALID(VV),
        .ADDR_W(AW), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .pix_data_req(pix_data_req),
        .pix_data(pix_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // One cycle at the falling edge: observe, update the model, drive the next inputs.
    task automatic cycle(input int ack_pct, input int val_pct, input int pop_mode,
                         input bit vs, input bit stray);
        bit ack, pop, dlv, rise;
        int a;
        logic [15:0] d;
        @(negedge clk);
        while (owed_next.size() > 0) owed_q.push_back(owed_next.pop_front());
        if (model_q.size() > 0) begin
            if (pix_data !== model_q[0]) head_bad++;
        end else if (pix_data !== 16'h0000) head_bad++;
        if (rd_req && req_held && rd_addr !== held_addr) addr_unstable++;

        pop = (pop_mode == 1) ||
              (pop_mode == 2 && model_q.size() > 0 && $urandom_range(1, 0) == 1);
        if (pop) begin
            pop_got.push_back(pix_data);
            if (model_q.size() > 0) void'(model_q.pop_front());
            else uf_exp = 1;
        end
        pix_data_req = pop;

        ack = rd_req && (int'($urandom_range(99, 0)) < ack_pct);
        if (ack) begin
            if (stale_req) stale_req = 0;
            else req_log.push_back(int'(rd_addr));
            for (int i = 0; i < int'(BL); i++) owed_next.push_back(int'(rd_addr) + i);
        end
        rd_ack    = ack;
        req_held  = rd_req && !ack;
        held_addr = rd_addr;

        dlv = owed_q.size() > 0 && (int'($urandom_range(99, 0)) < val_pct);
        if (dlv) begin
            a        = owed_q.pop_front();
            d        = sdram[4'(a - int'(BASE))];
            rd_valid = 1'b1;
            rd_data  = d;
            if (discard > 0) discard--;
            else model_q.push_back(d);
        end else if (stray && owed_q.size() == 0 && owed_next.size() == 0) begin
            rd_valid = 1'b1;
            rd_data  = 16'hBEEF;
        end else begin
            rd_valid = 1'b0;
            rd_data  = 16'($urandom);
        end

        rise  = vs && !vsync;
        vsync = vs;
        if (rise) begin
            uf_exp = 0;
            model_q.delete();
            discard   = owed_q.size() + owed_next.size() + (req_held ? int'(BL) : 0);
            stale_req = req_held;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; vsync = 1'b0; pix_data_req = 1'b0;
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vsync = ~vsync;
        end
        checks++;
        if (rd_addr !== 24'h000100) begin
            errors++; $display("FAIL reset_addr got %h want 000100", rd_addr);
        end
        vsync = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle(100, 0, 0, 0, 0);
            if (rd_req !== 1'b0 || underflow !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_idle got %0d bad cycles want 0", bad); end
        checks++;
        if (req_log.size() != 0) begin
            errors++; $display("FAIL reset_noreq got %0d requests want 0", req_log.size());
        end
        checks++;
        if (pix_data !== 16'h0) begin errors++; $display("FAIL reset_pix got %h want 0000", pix_data); end
        checks++;
        if (head_bad != 0) begin errors++; $display("FAIL reset_head got %0d want 0", head_bad); end
    endtask

    task automatic test_requests();
        for (int i = 0; i < int'(FRAME); i++) sdram[i] = 16'(16'h1000 + i);
        cycle(100, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) cycle(100, 0, 0, 0, 0);
        checks++;
        if (req_log.size() != 2) begin
            errors++; $display("FAIL req_count got %0d want 2", req_log.size());
        end else begin
            checks++;
            if (req_log[0] != 32'h100) begin errors++; $display("FAIL req0_addr got %h want 100", req_log[0]); end
            checks++;
            if (req_log[1] != 32'h104) begin errors++; $display("FAIL req1_addr got %h want 104", req_log[1]); end
        end
        checks++;
        if (rd_req !== 1'b0) begin errors++; $display("FAIL req_idle got %b want 0", rd_req); end
    endtask

    task automatic test_pop();
        int n = 0;
        while (model_q.size() < 8 && n < 30) begin cycle(100, 100, 0, 0, 0); n++; end
        cycle(100, 100, 0, 0, 0);
        checks++;
        if (model_q.size() != 8) begin errors++; $display("FAIL fill_timeout got %0d words want 8", model_q.size()); end
        checks++;
        if (pix_data !== 16'h1000) begin errors++; $display("FAIL head_first got %h want 1000", pix_data); end
        pop_got.delete();
        for (int i = 0; i < 3; i++) cycle(100, 100, 1, 0, 0);
        cycle(100, 100, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pop_got[i] !== 16'(16'h1000 + i)) begin
                errors++; $display("FAIL pop_%0d got %h want %h", i, pop_got[i], 16'(16'h1000 + i));
            end
        end
        checks++;
        if (pix_data !== 16'h1003) begin errors++; $display("FAIL head_after got %h want 1003", pix_data); end
        checks++;
        if (rd_req !== 1'b0 || req_log.size() != 2) begin
            errors++; $display("FAIL credit3 got rd_req %b reqs %0d want 0 and 2", rd_req, req_log.size());
        end
        cycle(100, 0, 1, 0, 0);
        n = 0;
        while (req_log.size() < 3 && n < 5) begin cycle(100, 0, 0, 0, 0); n++; end
        checks++;
        if (req_log.size() != 3) begin
            errors++; $display("FAIL credit4 got %0d requests want 3", req_log.size());
        end else begin
            checks++;
            if (req_log[2] != 32'h108) begin errors++; $display("FAIL req2_addr got %h want 108", req_log[2]); end
        end
    endtask

    task automatic test_underflow();
        int n = 0;
        int held = 0;
        while (!(req_log.size() == 4 && owed_q.size() == 0 && owed_next.size() == 0 &&
                 model_q.size() == 0) && n < 300) begin
            cycle(100, 100, 2, 0, 0); n++;
        end
        cycle(100, 100, 0, 0, 0);
        checks++;
        if (n >= 300) begin errors++; $display("FAIL drain_timeout got %0d cycles want <300", n); end
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL uf_before got %b want 0", underflow); end
        cycle(100, 100, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(100, 100, 0, 0, 0);
            if (underflow !== uf_exp) held++;
        end
        checks++;
        if (held != 0 || uf_exp != 1) begin
            errors++; $display("FAIL uf_sticky got %0d bad cycles want 0", held);
        end
        checks++;
        if (pop_got[pop_got.size() - 1] !== 16'h0) begin
            errors++; $display("FAIL empty_pop got %h want 0000", pop_got[pop_got.size() - 1]);
        end
        cycle(100, 100, 0, 1, 0);
        cycle(100, 100, 0, 0, 0);
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got %b want 0", underflow); end
    endtask

    task automatic test_full_frame();
        int n = 0;
        for (int i = 0; i < int'(FRAME); i++) sdram[i] = 16'($urandom_range(16'hFFFF, 1));
        cycle(100, 100, 0, 1, 0);
        req_log.delete();
        pop_got.delete();
        while (pop_got.size() < int'(FRAME) && n < 600) begin cycle(70, 70, 2, 0, 0); n++; end
        for (int i = 0; i < 20; i++) cycle(100, 100, 0, 0, 0);
        cycle(100, 100, 0, 0, 1);
        cycle(100, 100, 0, 0, 0);
        cycle(100, 100, 0, 0, 0);
        checks++;
        if (pop_got.size() != int'(FRAME)) begin
            errors++; $display("FAIL frame_pops got %0d want %0d", pop_got.size(), FRAME);
        end else begin
            for (int i = 0; i < int'(FRAME); i++) begin
                checks++;
                if (pop_got[i] !== sdram[i]) begin
                    errors++; $display("FAIL frame_word%0d got %h want %h", i, pop_got[i], sdram[i]);
                end
            end
        end
        checks++;
        if (req_log.size() != 4) begin
            errors++; $display("FAIL frame_reqs got %0d want 4", req_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (req_log[i] != int'(BASE) + 4 * i) begin
                    errors++; $display("FAIL frame_addr%0d got %h want %h", i, req_log[i], int'(BASE) + 4 * i);
                end
            end
        end
        checks++;
        if (rd_req !== 1'b0 || pix_data !== 16'h0 || underflow !== 1'b0) begin
            errors++; $display("FAIL frame_end got req %b pix %h uf %b want 0 0000 0", rd_req, pix_data, underflow);
        end
        checks++;
        if (head_bad != 0) begin errors++; $display("FAIL frame_head got %0d want 0", head_bad); end
    endtask

    task automatic test_flush_inflight();
        int n = 0;
        for (int i = 0; i < int'(FRAME); i++) sdram[i] = 16'($urandom_range(16'hFFFF, 1));
        cycle(100, 0, 0, 1, 0);
        req_log.delete();
        pop_got.delete();
        while (req_log.size() < 1 && n < 10) begin cycle(100, 0, 0, 0, 0); n++; end
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
        checks++;
        if (rd_req !== 1'b1 || rd_addr !== 24'h000104) begin
            errors++; $display("FAIL pend_setup got req %b addr %h want 1 000104", rd_req, rd_addr);
        end
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
        checks++;
        if (rd_req !== 1'b1 || rd_addr !== 24'h000104) begin
            errors++; $display("FAIL pend_hold got req %b addr %h want 1 000104", rd_req, rd_addr);
        end
        req_log.delete();
        n = 0;
        while (req_log.size() < 1 && n < 40) begin cycle(100, 100, 0, 0, 0); n++; end
        checks++;
        if (req_log.size() != 1 || req_log[0] != 32'h100) begin
            errors++; $display("FAIL restart_addr got %0d reqs first %h want 1 100",
                               req_log.size(), (req_log.size() > 0) ? req_log[0] : -1);
        end
        checks++;
        if (pix_data !== 16'h0) begin errors++; $display("FAIL flush_empty got %h want 0000", pix_data); end
        n = 0;
        while (pop_got.size() < 8 && n < 100) begin cycle(100, 100, 2, 0, 0); n++; end
        checks++;
        if (pop_got.size() != 8) begin
            errors++; $display("FAIL restart_pops got %0d want 8", pop_got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (pop_got[i] !== sdram[i]) begin
                    errors++; $display("FAIL restart_word%0d got %h want %h", i, pop_got[i], sdram[i]);
                end
            end
        end
        checks++;
        if (head_bad != 0 || addr_unstable != 0) begin
            errors++; $display("FAIL flush_consistency got head %0d addr %0d want 0 0", head_bad, addr_unstable);
        end
    endtask

    initial begin
        test_reset();
        test_requests();
        test_pop();
        test_underflow();
        test_full_frame();
        test_flush_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_pix_prefetch.md
# disp_pix_prefetch

Display-side pixel prefetcher that feeds the VGA timing generator's `pix_data` input. It issues fixed-length burst read requests to the frame-buffer (SDRAM) read port and buffers returned RGB565 words in a small show-ahead FIFO. It pops one word per `pix_data_req` cycle and restarts at the frame base address on every vsync rising edge.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in words; power of 2, ≥ 2×`BURST_LEN`.
- `BURST_LEN`, 8: words per read request; power of 2.
- `H_VALID`, 1024: active pixels per line.
- `V_VALID`, 768: active lines per frame.
- `ADDR_W`, 24: read address width (word address).
- `BASE_ADDR`, 0: frame start address.

Ports:
- `clk`, in, 1: pixel clock; all logic is in this domain.
- `rst`, in, 1: asynchronous, active-high reset. One clock; reset asynchronous active-high.
- `vsync`, in, 1: active-high vertical sync from the timing generator.
- `pix_data_req`, in, 1: pop request; the current head word is consumed this cycle.
- `pix_data`, out, 16: FIFO head word (show-ahead); 16'h0000 when the FIFO is empty.
- `rd_req`, out, 1: burst read request.
- `rd_addr`, out, ADDR_W: burst start address; stable while `rd_req` is high.
- `rd_ack`, in, 1: request accepted in this cycle.
- `rd_valid`, in, 1: a returned read word is valid.
- `rd_data`, in, 16: returned read word.
- `underflow`, out, 1: sticky flag, set when a pop is requested while the FIFO is empty; cleared on the next vsync rise.

## Operation
- Frame size: `FRAME_WORDS` = H_VALID×V_VALID. `req_cnt` counts words requested in the current frame; it is wide enough to hold `FRAME_WORDS`, which is 21 bits at the default size.
- `outstanding` counts words that have been requested and acknowledged but not yet returned. It increases by `BURST_LEN` on each `rd_ack` and decreases by 1 on each `rd_valid`; both can happen in the same cycle. `fifo_cnt` counts words currently held in the FIFO.
- Credit rule: a new request may be raised only when DEPTH − fifo_cnt − outstanding ≥ BURST_LEN and req_cnt < FRAME_WORDS.
- Frame start is detected on the vsync rising edge: `vsync` is registered once and the edge is taken as `vsync & ~vsync_d`.
- State machine:
  - IDLE (reset state): no requests. A vsync rise goes to FLUSH.
  - FLUSH: the FIFO is cleared, `rd_addr` is set to BASE_ADDR, `req_cnt` to 0 and `underflow` to 0. Returned `rd_valid` words are dropped. The block stays in FLUSH until `outstanding` = 0 and `rd_req` = 0, then goes to RUN.
  - RUN: requests are issued per the credit rule and returned words are pushed into the FIFO. A vsync rise goes to FLUSH.
- Request handshake:
  - `rd_req` stays asserted until the cycle in which `rd_ack` is sampled high.
  - On that edge: `rd_addr` += BURST_LEN, `req_cnt` += BURST_LEN, `outstanding` += BURST_LEN.
  - A request that is pending when vsync rises stays asserted until acked. Its data is counted in `outstanding` and discarded in FLUSH.
- Pop:
  - `pix_data_req` & non-empty: read pointer +1.
  - `pix_data_req` & empty: no pop, `pix_data` = 0, `underflow` set to 1.
- `rd_valid` with `outstanding` = 0 is a protocol error: the word is ignored and no counter changes.
- Push and pop in the same cycle leave `fifo_cnt` unchanged. Pointers wrap modulo DEPTH.
- The credit rule guarantees a push never arrives while the FIFO is full.

## Timing
- Reset values: `rd_req` 0, `rd_addr` BASE_ADDR, `pix_data` 0 (FIFO empty), `underflow` 0, state IDLE, all counters 0.
- vsync rise at input edge N: `vsync_d` samples at N, the edge is detected during cycle N+1, and the state is FLUSH from edge N+1.
- FLUSH lasts at least 1 cycle. If nothing is in flight, RUN starts the following cycle, and `rd_req` may rise on the first RUN cycle.
- Write to read: a word pushed at edge k appears on `pix_data` after edge k (combinational head read from the registered array). `pix_data` is valid together with `pix_data_req` for direct use by the downstream timing block.
- Back-to-back requests: after an ack at edge k, `rd_req` may remain high for the next burst if credit allows. Credit is evaluated from the post-ack counter values.
- Once `req_cnt` = FRAME_WORDS, no further requests are made until the next vsync rise.
- Reset asserted mid-operation: all state returns to its reset value immediately (asynchronously). Data in flight after reset is released is ignored by the `outstanding` = 0 rule.

## Test plan
Bench parameters: H_VALID=8, V_VALID=2, DEPTH=8, BURST_LEN=4, BASE_ADDR=0x100.
- Reset with a vsync toggling pattern, with no vsync rise after release → `rd_req`=0, `pix_data`=0, `underflow`=0 indefinitely.
- vsync rise, `rd_ack` returned one cycle after each request, no pops → exactly two requests, at 0x100 and 0x104, then `rd_req` stays low.
- Return 8 words 0x1000..0x1007, then pulse `pix_data_req` for 3 cycles → `pix_data` reads 0x1000, 0x1001, 0x1002, head becomes 0x1003, and a third request at 0x108 is issued once credit reaches 4.
- Pop on an empty FIFO → `pix_data`=0 and `underflow`=1, held until the next vsync rise, where it clears.
- Run a full frame with continuous acks and data → exactly 4 requests (0x100..0x10C), 16 words popped in order, then no requests.
- vsync rise with 4 words outstanding and `rd_req` pending → `rd_req` held until ack, all 8 in-flight words dropped, FIFO empty, and the first RUN request goes to 0x100.
